// File: rtl/cim_mem_pkg.sv
// Shared constants, scan-mode encoding and PE tile packing for the CIM output memory.
package cim_mem_pkg;

  localparam int DEPTH     = 256;
  localparam int WORD_W    = 512;
  localparam int TILE      = 6;
  localparam int PIX_W     = 12;
  localparam int OD_W      = 8;
  localparam int ADDR_W    = 8;
  localparam int TILE_BITS = TILE * TILE * PIX_W;

  typedef enum logic [1:0] {
    SCAN_WRITE = 2'b00,
    PE_WRITE   = 2'b01,
    IDLE       = 2'b10,
    SCAN_READ  = 2'b11
  } scan_mode_e;

  typedef logic signed [0:TILE-1][0:TILE-1][PIX_W-1:0] tile_t;

  // Row-major tile elements in the low bits, depth tag above them, zero padding on top.
  function automatic logic [WORD_W-1:0] pack_tile(input tile_t tile, input logic [OD_W-1:0] od);
    logic [WORD_W-1:0] word;
    word = '0;
    for (int i = 0; i < TILE; i++) begin
      for (int j = 0; j < TILE; j++) begin
        word[(i*TILE+j)*PIX_W +: PIX_W] = tile[i][j];
      end
    end
    word[TILE_BITS +: OD_W] = od;
    return word;
  endfunction

endpackage

// File: rtl/cim_sram.sv
// Two-write-port storage array with one registered read port; port 2 wins on address collision.
module cim_sram #(
  parameter int DEPTH  = 256,
  parameter int WORD_W = 512,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] waddr1_i,
  input  logic [WORD_W-1:0] wdata1_i,
  input  logic              we2_i,
  input  logic [ADDR_W-1:0] waddr2_i,
  input  logic [WORD_W-1:0] wdata2_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] rdata_d;

  // Array writes: contents are never reset, writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && we1_i) mem_q[waddr1_i] <= wdata1_i;
    if (rst_n && we2_i) mem_q[waddr2_i] <= wdata2_i;
  end

  // Read-data next state: load on a read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cim_mem_top.sv
// CIM output memory: scan-chain and dual-PE write access to one word array, scan readout.
module cim_mem_top #(
  parameter int DEPTH  = cim_mem_pkg::DEPTH,
  parameter int WORD_W = cim_mem_pkg::WORD_W,
  parameter int TILE   = cim_mem_pkg::TILE,
  parameter int PIX_W  = cim_mem_pkg::PIX_W
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic signed [0:TILE-1][0:TILE-1][PIX_W-1:0] PE_tile_i_1,
  input  logic [7:0]                                  PE_od_i_1,
  input  logic [7:0]                                  PE_addr_i_1,
  input  logic                                        PE_valid_i_1,
  input  logic signed [0:TILE-1][0:TILE-1][PIX_W-1:0] PE_tile_i_2,
  input  logic [7:0]                                  PE_od_i_2,
  input  logic [7:0]                                  PE_addr_i_2,
  input  logic                                        PE_valid_i_2,
  input  logic [WORD_W-1:0]                           scan_in,
  input  logic [7:0]                                  scan_addr,
  input  logic [1:0]                                  scan_mode,
  output logic [WORD_W-1:0]                           scan_out
);

  import cim_mem_pkg::*;

  scan_mode_e        mode_s;
  logic              we1_s, we2_s, re_s;
  logic [7:0]        waddr1_s, waddr2_s;
  logic [WORD_W-1:0] wdata1_s, wdata2_s;
  logic [WORD_W-1:0] pe_word1_s, pe_word2_s;

  assign mode_s     = scan_mode_e'(scan_mode);
  assign pe_word1_s = pack_tile(PE_tile_i_1, PE_od_i_1);
  assign pe_word2_s = pack_tile(PE_tile_i_2, PE_od_i_2);

  // Mode decode and write-port steering; the scan path shares write port 1.
  always_comb begin
    we1_s    = 1'b0;
    we2_s    = 1'b0;
    re_s     = 1'b0;
    waddr1_s = PE_addr_i_1;
    waddr2_s = PE_addr_i_2;
    wdata1_s = pe_word1_s;
    wdata2_s = pe_word2_s;
    case (mode_s)
      SCAN_WRITE: begin
        we1_s    = 1'b1;
        waddr1_s = scan_addr;
        wdata1_s = scan_in;
      end
      PE_WRITE: begin
        we1_s = PE_valid_i_1;
        we2_s = PE_valid_i_2;
      end
      SCAN_READ: re_s = 1'b1;
      IDLE:      re_s = 1'b0;
      default: begin
        we1_s = 1'b0;
        we2_s = 1'b0;
        re_s  = 1'b0;
      end
    endcase
  end

  cim_sram #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .ADDR_W (8)
  ) u_sram (
    .clk      (clk),
    .rst_n    (rst_n),
    .we1_i    (we1_s),
    .waddr1_i (waddr1_s),
    .wdata1_i (wdata1_s),
    .we2_i    (we2_s),
    .waddr2_i (waddr2_s),
    .wdata2_i (wdata2_s),
    .re_i     (re_s),
    .raddr_i  (scan_addr),
    .rdata_o  (scan_out)
  );

endmodule

// File: tb/tb_cim_mem_top.sv
// Directed bench for cim_mem_top with hand-derived expected words.
module tb_cim_mem_top;

  typedef logic signed [0:5][0:5][11:0] btile_t;

  logic         clk;
  logic         rst_n;
  btile_t       t1, t2;
  logic [7:0]   od1, od2, a1, a2;
  logic         v1, v2;
  logic [511:0] scan_in;
  logic [7:0]   scan_addr;
  logic [1:0]   scan_mode;
  logic [511:0] scan_out;

  int n_checks = 0;
  int n_err    = 0;

  logic [511:0] dead_word;
  logic [511:0] held;
  logic [511:0] mixed;

  cim_mem_top dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PE_tile_i_1  (t1),
    .PE_od_i_1    (od1),
    .PE_addr_i_1  (a1),
    .PE_valid_i_1 (v1),
    .PE_tile_i_2  (t2),
    .PE_od_i_2    (od2),
    .PE_addr_i_2  (a2),
    .PE_valid_i_2 (v2),
    .scan_in      (scan_in),
    .scan_addr    (scan_addr),
    .scan_mode    (scan_mode),
    .scan_out     (scan_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic btile_t uni(input logic [11:0] v);
    btile_t t;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        t[i][j] = v;
    return t;
  endfunction

  function automatic logic [511:0] exp_uni(input logic [11:0] v, input logic [7:0] od);
    return {72'd0, od, {36{v}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] addr);
    scan_mode = 2'b11;
    scan_addr = addr;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; t1 = '0; t2 = '0; od1 = 8'd0; od2 = 8'd0; a1 = 8'd0; a2 = 8'd0;
    v1 = 1'b0; v2 = 1'b0; scan_in = '0; scan_addr = 8'd0; scan_mode = 2'b10;
    dead_word = {16{32'hDEADBEEF}};
    #2;
    chk("reset_out_async", scan_out, 512'd0);
    tick(); tick();
    chk("reset_out", scan_out, 512'd0);
    rst_n = 1'b1;

    // Scan fill 0..127 then readback with one-cycle latency
    scan_mode = 2'b00;
    for (int i = 0; i < 128; i++) begin
      scan_addr = 8'(i);
      scan_in   = 512'(i);
      tick();
    end
    for (int i = 0; i < 128; i++) begin
      rd(8'(i));
      chk($sformatf("scan_rd_%0d", i), scan_out, 512'(i));
    end

    // Dual PE write
    scan_mode = 2'b01;
    t1 = uni(12'h0CC); od1 = 8'h00; a1 = 8'd3; v1 = 1'b1;
    t2 = uni(12'h0DD); od2 = 8'h01; a2 = 8'd4; v2 = 1'b1;
    tick();
    v1 = 1'b0; v2 = 1'b0;
    rd(8'd3); chk("pe_dual_a3", scan_out, exp_uni(12'h0CC, 8'h00));
    rd(8'd4); chk("pe_dual_a4", scan_out, exp_uni(12'h0DD, 8'h01));
    rd(8'd5); chk("pe_dual_a5", scan_out, 512'd5);

    // Valid gating: only the first-cycle data lands
    scan_mode = 2'b01;
    t1 = uni(12'h0AA); od1 = 8'h00; a1 = 8'd5; v1 = 1'b1;
    t2 = uni(12'h0BB); od2 = 8'h00; a2 = 8'd6; v2 = 1'b1;
    tick();
    t1 = uni(12'h123); t2 = uni(12'h456); v1 = 1'b0; v2 = 1'b0;
    tick(); tick();
    rd(8'd5); chk("valid_gate_a5", scan_out, exp_uni(12'h0AA, 8'h00));
    rd(8'd6); chk("valid_gate_a6", scan_out, exp_uni(12'h0BB, 8'h00));

    // Collision: port 2 wins
    scan_mode = 2'b01;
    t1 = uni(12'h111); a1 = 8'd9; v1 = 1'b1;
    t2 = uni(12'h222); a2 = 8'd9; v2 = 1'b1;
    tick();
    v1 = 1'b0; v2 = 1'b0;
    rd(8'd9); chk("collision_a9", scan_out, exp_uni(12'h222, 8'h00));

    // Mode isolation: IDLE and SCAN_READ with live PE requests and all-ones scan data
    rd(8'd10);
    chk("iso_pre_a10", scan_out, 512'd10);
    scan_mode = 2'b10; scan_in = '1; scan_addr = 8'd11;
    t1 = uni(12'hFFF); a1 = 8'd10; v1 = 1'b1;
    t2 = uni(12'hFFF); a2 = 8'd11; v2 = 1'b1;
    held = scan_out;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("idle_hold_%0d", k), scan_out, 512'd10);
    end
    rd(8'd11); chk("iso_a11", scan_out, 512'd11);
    rd(8'd10); chk("iso_a10", scan_out, 512'd10);
    rd(8'd12); chk("iso_a12", scan_out, 512'd12);
    v1 = 1'b0; v2 = 1'b0; scan_in = '0;

    // Non-uniform tile checks element order, sign bits and the od field
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        t1[i][j] = 12'(i * 6 + j);
    t1[5][5] = -12'sd1;
    mixed = '0;
    for (int k = 0; k < 35; k++) mixed[k*12 +: 12] = 12'(k);
    mixed[431:420] = 12'hFFF;
    mixed[439:432] = 8'h5A;
    scan_mode = 2'b01; od1 = 8'h5A; a1 = 8'd20; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    rd(8'd20); chk("pack_order_a20", scan_out, mixed);

    // Write then read the same address on the next cycle
    scan_mode = 2'b00; scan_addr = 8'd30; scan_in = dead_word;
    tick();
    rd(8'd30); chk("wr_then_rd_a30", scan_out, dead_word);

    // IDLE holds the last read value
    scan_mode = 2'b10; scan_addr = 8'd0;
    tick(); tick();
    chk("idle_hold_dead", scan_out, dead_word);

    // Reset mid-read; in-flight write under reset discarded
    rd(8'd30);
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", scan_out, 512'd0);
    scan_mode = 2'b00; scan_addr = 8'd40; scan_in = '1;
    tick();
    chk("rst_held_zero", scan_out, 512'd0);
    scan_mode = 2'b10;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", scan_out, 512'd0);
    rd(8'd40); chk("post_rst_a40", scan_out, 512'd40);
    rd(8'd3);  chk("post_rst_a3", scan_out, exp_uni(12'h0CC, 8'h00));
    rd(8'd30); chk("post_rst_a30", scan_out, dead_word);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cim_mem_top.md
CIM_MEM_TOP -- requirements
Module: cim_mem_top

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- PE_tile_i_1  in  signed 12 x [0:5][0:5]  PE1 output tile.
- PE_od_i_1  in  8  PE1 output-depth tag.
- PE_addr_i_1  in  8  PE1 word address.
- PE_valid_i_1  in  1  PE1 write request.
- PE_tile_i_2, PE_od_i_2, PE_addr_i_2, PE_valid_i_2  in  same widths  PE2 port.
- scan_in  in  512  off-chip write word.
- scan_addr  in  8  off-chip word address.
- scan_mode  in  2  mode select.
- scan_out  out  512  off-chip read word.
REQ-002 SHALL have parameters, one per line: name, default, meaning.
- DEPTH, 256, number of memory words.
- WORD_W, 512, word width in bits.
- TILE, 6, tile edge length.
- PIX_W, 12, tile element width.

Function
REQ-003 SHALL hold DEPTH x WORD_W storage, addressed directly by the 8-bit address (no offset, no wrap logic needed).
REQ-004 SHALL decode scan_mode as follows: 2'b00 = SCAN_WRITE, 2'b01 = PE_WRITE, 2'b10 = IDLE, 2'b11 = SCAN_READ.
REQ-005 SCAN_WRITE: on every posedge clk, mem[scan_addr] <= scan_in. PE requests are ignored.
REQ-006 PE_WRITE: on a posedge with PE_valid_i_k = 1, mem[PE_addr_i_k] <= packed word of port k. Scan inputs are ignored.
REQ-007 The packed word SHALL be built as follows:
- bits [(i*6+j)*12 +: 12] = PE_tile_i_k[i][j], for i, j in 0..5, giving bits [431:0].
- bits [439:432] = PE_od_i_k.
- bits [511:440] = 0.
REQ-008 PE write behaviour SHALL be:
- Both ports valid, different addresses: both words are written in the same cycle.
- Both ports valid, same address: port 2's word is stored.
- Valid low on a port: no write from that port.
REQ-009 IDLE: no memory writes occur, and scan_out holds its value.
REQ-010 SCAN_READ: on each posedge, scan_out <= mem[scan_addr].
- Read latency is 1 clk.
- No writes occur in this mode.
REQ-011 In modes other than SCAN_READ, scan_out SHALL hold its last value.
REQ-012 A write followed by a read of the same address in the next cycle SHALL return the new data.

Reset
REQ-013 While rst_n = 0, scan_out SHALL be 0 and no memory write SHALL occur.
REQ-014 Memory contents SHALL NOT be reset; they are undefined until written.
REQ-015 If reset is asserted mid-operation, a write in flight that cycle SHALL be discarded. Operation resumes on the first posedge after rst_n rises.

Structure
REQ-016 A shared package cim_mem_pkg SHALL hold:
- the constants DEPTH, WORD_W, TILE, PIX_W;
- the scan_mode enum {SCAN_WRITE, PE_WRITE, IDLE, SCAN_READ};
- the tile-packing function.
REQ-017 SHALL instantiate one sub-module, cim_sram: a DEPTH x WORD_W array with two write ports (port 2 has priority) and one registered read port. The top level contains the mode decode, the tile packing and the write-port muxing.

Verification
REQ-018 Scan fill/readback: SCAN_WRITE with scan_in = i at addresses 0..127, then SCAN_READ of 0..127 -> scan_out = i one clk after each address is applied.
REQ-019 Dual PE write: PE_WRITE with PE1 (tile all 0x0CC, od 0, addr 3) and PE2 (tile all 0x0DD, od 1, addr 4), then readback:
- addr 3 -> 36 x 0x0CC in [431:0], 0x00 in [439:432], zero above.
- addr 4 -> 0x0DD pattern with od = 0x01.
- addr 5 -> still reads 5.
REQ-020 Valid gating: tile 0xAA to addr 5 and tile 0xBB to addr 6 with valid = 1 for one cycle, then valid = 0 with new data -> addresses 5 and 6 hold only the first data.
REQ-021 Collision: both ports write addr 9 in the same cycle (PE1 tile 0x111, PE2 tile 0x222) -> addr 9 reads the 0x222 pattern.
REQ-022 Mode isolation: in SCAN_READ and IDLE with PE valid = 1 and scan_in = all ones -> memory is unchanged on readback; in IDLE, scan_out is stable.
REQ-023 Reset: rst_n pulsed low mid-SCAN_READ -> scan_out = 0 immediately; data written before the reset reads back unchanged afterwards.
